// File: rtl/axi_wr_arbiter_if.sv
// Command/data path from the arbiter to the shared AXI write engine, plus the
// AW/W/B handshakes the arbiter snoops to track each transaction.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

interface axi_wr_arbiter_if;
    logic [`ADDR_BITS-1:0] m_awaddr;
    logic [`LEN_BITS-1:0]  m_awlen;
    logic [`SIZE_BITS-1:0] m_awsize;
    logic [1:0]            m_awburst;
    logic [3:0]            m_awcache;
    logic                  m_awvalid;
    logic [`DATA_BITS-1:0] m_wdata;

    logic                  bus_aw_valid;
    logic                  bus_aw_ready;
    logic                  bus_w_valid;
    logic                  bus_w_ready;
    logic                  bus_b_valid;
    logic                  bus_b_ready;
    logic [1:0]            bus_b_resp;

    modport master (
        output m_awaddr, m_awlen, m_awsize, m_awburst, m_awcache, m_awvalid, m_wdata,
        input  bus_aw_valid, bus_aw_ready, bus_w_valid, bus_w_ready,
        input  bus_b_valid, bus_b_ready, bus_b_resp
    );

    modport slave (
        input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awcache, m_awvalid, m_wdata,
        output bus_aw_valid, bus_aw_ready, bus_w_valid, bus_w_ready,
        output bus_b_valid, bus_b_ready, bus_b_resp
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write engine among NUM_REQ requesters.
// Define AXI_WR_ARB_WDT_EN to add a per-transaction watchdog and sticky wdt_err.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module axi_wr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            aclk,
    input  logic                            areset_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*`ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*`LEN_BITS-1:0]    req_len,
    input  logic [NUM_REQ*`SIZE_BITS-1:0]   req_size,
    input  logic [NUM_REQ*2-1:0]            req_burst,
    input  logic [NUM_REQ*4-1:0]            req_cache,
    input  logic [NUM_REQ*`DATA_BITS-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              data_pop,
    output logic [NUM_REQ-1:0]              done,
    output logic [1:0]                      done_resp,
    output logic                            busy,
`ifdef AXI_WR_ARB_WDT_EN
    output logic                            wdt_err,
`endif
    axi_wr_arbiter_if.master                bus
);

    localparam int          IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned NREQ_U = NUM_REQ;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_win;
    logic [NUM_REQ-1:0]    w_win_oh;
    logic                  w_found;
    int unsigned           w_c;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_data_pop;
    logic [NUM_REQ-1:0]    r_done;
    logic [1:0]            r_done_resp;
    logic [`ADDR_BITS-1:0] r_awaddr;
    logic [`LEN_BITS-1:0]  r_awlen;
    logic [`SIZE_BITS-1:0] r_awsize;
    logic [1:0]            r_awburst;
    logic [3:0]            r_awcache;
    logic                  r_awvalid;
    logic [`LEN_BITS:0]    r_beat_cnt;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_last_beat;
    logic                  w_timeout;

    assign w_aw_hs     = bus.bus_aw_valid & bus.bus_aw_ready;
    assign w_w_hs      = bus.bus_w_valid & bus.bus_w_ready;
    assign w_b_hs      = bus.bus_b_valid & bus.bus_b_ready;
    assign w_last_beat = (r_beat_cnt == {1'b0, r_awlen});

    // First set request after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_win    = r_ptr;
        w_win_oh = '0;
        w_c      = 0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            w_c = (32'(r_ptr) + k) % NREQ_U;
            if (!w_found && req[w_c[IDX_W-1:0]]) begin
                w_found               = 1'b1;
                w_win                 = w_c[IDX_W-1:0];
                w_win_oh              = '0;
                w_win_oh[w_c[IDX_W-1:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found)               w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_aw_hs)               w_state_nxt = S_DATA;
            S_DATA:  if (w_w_hs && w_last_beat) w_state_nxt = S_RESP;
            S_RESP:  if (w_b_hs)                w_state_nxt = S_IDLE;
            default:                            w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_idx       <= '0;
            r_gnt       <= '0;
            r_data_pop  <= '0;
            r_done      <= '0;
            r_done_resp <= '0;
            r_awaddr    <= '0;
            r_awlen     <= '0;
            r_awsize    <= '0;
            r_awburst   <= '0;
            r_awcache   <= '0;
            r_awvalid   <= 1'b0;
            r_beat_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_data_pop <= '0;
            r_done     <= '0;
            if (w_timeout) begin
                r_done      <= r_gnt;
                r_done_resp <= 2'b10;
                r_gnt       <= '0;
                r_awvalid   <= 1'b0;
                r_beat_cnt  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_found) begin
                        r_gnt     <= w_win_oh;
                        r_idx     <= w_win;
                        r_ptr     <= w_win;
                        r_awaddr  <= req_addr[w_win*`ADDR_BITS +: `ADDR_BITS];
                        r_awlen   <= req_len[w_win*`LEN_BITS +: `LEN_BITS];
                        r_awsize  <= req_size[w_win*`SIZE_BITS +: `SIZE_BITS];
                        r_awburst <= req_burst[w_win*2 +: 2];
                        r_awcache <= req_cache[w_win*4 +: 4];
                        r_awvalid <= 1'b1;
                    end
                    S_ISSUE: if (w_aw_hs) r_awvalid <= 1'b0;
                    S_DATA: if (w_w_hs) begin
                        r_data_pop <= r_gnt;
                        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
                    end
                    S_RESP: if (w_b_hs) begin
                        r_done      <= r_gnt;
                        r_done_resp <= bus.bus_b_resp;
                        r_gnt       <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef AXI_WR_ARB_WDT_EN
    localparam int WDT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDT_W-1:0] r_wdt_cnt;
    logic             r_wdt_err;

    // Fires on the edge where the count would reach TIMEOUT_CYCLES.
    assign w_timeout = (r_state != S_IDLE) && (r_wdt_cnt == WDT_W'(TIMEOUT_CYCLES - 1));
    assign wdt_err   = r_wdt_err;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_wdt_cnt <= '0;
            r_wdt_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_state_nxt != r_state) r_wdt_cnt <= '0;
            else                                             r_wdt_cnt <= r_wdt_cnt + 1'b1;
            if (w_timeout) r_wdt_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign gnt           = r_gnt;
    assign data_pop      = r_data_pop;
    assign done          = r_done;
    assign done_resp     = r_done_resp;
    assign busy          = (r_state != S_IDLE);
    assign bus.m_awaddr  = r_awaddr;
    assign bus.m_awlen   = r_awlen;
    assign bus.m_awsize  = r_awsize;
    assign bus.m_awburst = r_awburst;
    assign bus.m_awcache = r_awcache;
    assign bus.m_awvalid = r_awvalid;
    assign bus.m_wdata   = (r_state == S_ISSUE || r_state == S_DATA) ?
                           req_wdata[r_idx*`DATA_BITS +: `DATA_BITS] : '0;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized self-checking bench for axi_wr_arbiter; plays engine and slave on the
// snooped bus and predicts grants from a round-robin model.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module tb_axi_wr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int AW = `ADDR_BITS;
    localparam int LW = `LEN_BITS;
    localparam int SW = `SIZE_BITS;
    localparam int DW = `DATA_BITS;
`ifdef AXI_WR_ARB_WDT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    logic                    aclk = 1'b0;
    logic                    areset_n = 1'b0;
    logic [NUM_REQ-1:0]      req = '0;
    logic [NUM_REQ*AW-1:0]   req_addr = '0;
    logic [NUM_REQ*LW-1:0]   req_len = '0;
    logic [NUM_REQ*SW-1:0]   req_size = '0;
    logic [NUM_REQ*2-1:0]    req_burst = '0;
    logic [NUM_REQ*4-1:0]    req_cache = '0;
    logic [NUM_REQ*DW-1:0]   req_wdata = '0;
    logic [NUM_REQ-1:0]      gnt;
    logic [NUM_REQ-1:0]      data_pop;
    logic [NUM_REQ-1:0]      done;
    logic [1:0]              done_resp;
    logic                    busy;
`ifdef AXI_WR_ARB_WDT_EN
    logic                    wdt_err;
`endif

    axi_wr_arbiter_if u_if();

    axi_wr_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) u_dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_size  (req_size),
        .req_burst (req_burst),
        .req_cache (req_cache),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .data_pop  (data_pop),
        .done      (done),
        .done_resp (done_resp),
        .busy      (busy),
`ifdef AXI_WR_ARB_WDT_EN
        .wdt_err   (wdt_err),
`endif
        .bus       (u_if)
    );

    always #5 aclk = ~aclk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          m_ptr = NUM_REQ - 1;
    logic [1:0]  m_last_resp = 2'b00;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference rule: next owner is the nearest requester after the last winner.
    function automatic int rr_next(input logic [NUM_REQ-1:0] mask, input int last);
        for (int d = 1; d <= NUM_REQ; d++)
            if (mask[(last + d) % NUM_REQ]) return (last + d) % NUM_REQ;
        return -1;
    endfunction

    task automatic bus_idle;
        u_if.bus_aw_valid = 1'b0;
        u_if.bus_aw_ready = 1'b0;
        u_if.bus_w_valid  = 1'b0;
        u_if.bus_w_ready  = 1'b0;
        u_if.bus_b_valid  = 1'b0;
        u_if.bus_b_ready  = 1'b0;
        u_if.bus_b_resp   = 2'b00;
    endtask

    task automatic rand_fields;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*AW +: AW]  = AW'($urandom);
            req_len[i*LW +: LW]   = LW'($urandom_range(0, 5));
            req_size[i*SW +: SW]  = SW'($urandom);
            req_burst[i*2 +: 2]   = 2'($urandom);
            req_cache[i*4 +: 4]   = 4'($urandom);
            req_wdata[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "/gnt"}, gnt, '0);
        chk({tag, "/data_pop"}, data_pop, '0);
        chk({tag, "/done"}, done, '0);
        chk({tag, "/done_resp"}, done_resp, '0);
        chk({tag, "/busy"}, busy, '0);
        chk({tag, "/awvalid"}, u_if.m_awvalid, '0);
        chk({tag, "/awaddr"}, u_if.m_awaddr, '0);
        chk({tag, "/wdata"}, u_if.m_wdata, '0);
    endtask

    // w_mode: 0 always ready, 1 toggling ready, 2 random ready (never low twice).
    // b_stall < 0 withholds the B response entirely; abort_beats >= 0 resets mid-data.
    task automatic do_txn(input string tag, input int aw_stall, input int w_mode,
                          input int b_stall, input logic [1:0] resp, input int abort_beats,
                          input bit drop_req, output logic [NUM_REQ-1:0] got_gnt);
        int exp_w, cycles, accepted, pops, beats, guard;
        bit hs, last_low;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_len;
        logic [SW-1:0] e_size;
        logic [1:0]    e_burst;
        logic [3:0]    e_cache;
        logic [DW-1:0] e_data;

        got_gnt = '0;
        exp_w = rr_next(req, m_ptr);
        tick;
        cycles = 1;
        chk({tag, "/done_low"}, done, '0);
        chk({tag, "/done_resp_hold"}, done_resp, m_last_resp);
        while (gnt == '0 && cycles < 20) begin
            tick;
            cycles++;
        end
        got_gnt = gnt;
        chk({tag, "/gnt"}, gnt, oh(exp_w));
        chk({tag, "/gnt_latency"}, cycles, 1);
        if (gnt == '0) begin
            bus_idle();
            return;
        end
        m_ptr   = exp_w;
        e_addr  = req_addr[exp_w*AW +: AW];
        e_len   = req_len[exp_w*LW +: LW];
        e_size  = req_size[exp_w*SW +: SW];
        e_burst = req_burst[exp_w*2 +: 2];
        e_cache = req_cache[exp_w*4 +: 4];
        beats   = int'(e_len) + 1;
        chk({tag, "/awvalid"}, u_if.m_awvalid, 1);
        chk({tag, "/awaddr"}, u_if.m_awaddr, e_addr);
        chk({tag, "/awlen"}, u_if.m_awlen, e_len);
        chk({tag, "/awsize"}, u_if.m_awsize, e_size);
        chk({tag, "/awburst"}, u_if.m_awburst, e_burst);
        chk({tag, "/awcache"}, u_if.m_awcache, e_cache);
        chk({tag, "/busy"}, busy, 1);

        // Requester side churns after the grant; captured command must not move.
        rand_fields();
        if (drop_req) req[exp_w] = 1'b0;

        u_if.bus_aw_valid = 1'b1;
        u_if.bus_aw_ready = 1'b0;
        for (int s = 0; s < aw_stall; s++) begin
            tick;
            chk({tag, "/aw_stall_valid"}, u_if.m_awvalid, 1);
            chk({tag, "/aw_stall_addr"}, u_if.m_awaddr, e_addr);
            chk({tag, "/aw_stall_len"}, u_if.m_awlen, e_len);
        end
        u_if.bus_aw_ready = 1'b1;
        tick;
        chk({tag, "/awvalid_drop"}, u_if.m_awvalid, 0);
        u_if.bus_aw_valid = 1'b0;
        u_if.bus_aw_ready = 1'b0;

        accepted = 0;
        pops = 0;
        guard = 0;
        last_low = 1'b0;
        while (accepted < beats && guard < 64) begin
            u_if.bus_w_valid = 1'b1;
            case (w_mode)
                0:       hs = 1'b1;
                1:       hs = (guard % 2) == 1;
                default: hs = last_low ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            last_low = !hs;
            u_if.bus_w_ready = hs;
            e_data = DW'($urandom);
            req_wdata[exp_w*DW +: DW] = e_data;
            #1;
            chk({tag, "/wdata_mux"}, u_if.m_wdata, e_data);
            tick;
            if (hs) accepted++;
            chk({tag, "/data_pop"}, data_pop, hs ? oh(exp_w) : '0);
            if (data_pop != '0) pops++;
            guard++;
            if (abort_beats >= 0 && accepted == abort_beats) begin
                areset_n = 1'b0;
                #1;
                check_reset_outputs({tag, "/abort"});
                bus_idle();
                tick;
                tick;
                chk({tag, "/abort_no_done"}, done, '0);
                areset_n = 1'b1;
                m_ptr = NUM_REQ - 1;
                m_last_resp = 2'b00;
                return;
            end
        end
        u_if.bus_w_valid = 1'b0;
        u_if.bus_w_ready = 1'b0;
        chk({tag, "/pop_count"}, pops, beats);
        chk({tag, "/gnt_held"}, gnt, oh(exp_w));

        u_if.bus_b_valid = 1'b1;
        u_if.bus_b_resp  = resp;
        u_if.bus_b_ready = 1'b0;
        if (b_stall < 0) begin
`ifdef AXI_WR_ARB_WDT_EN
            u_if.bus_b_valid = 1'b0;
            for (int s = 1; s < TB_TIMEOUT; s++) begin
                tick;
                chk({tag, "/wdt_wait"}, done, '0);
            end
            tick;
            chk({tag, "/wdt_done"}, done, oh(exp_w));
            chk({tag, "/wdt_resp"}, done_resp, 2'b10);
            chk({tag, "/wdt_gnt"}, gnt, '0);
            chk({tag, "/wdt_err"}, wdt_err, 1);
            m_last_resp = 2'b10;
`endif
            bus_idle();
            return;
        end
        for (int s = 0; s < b_stall; s++) begin
            tick;
            chk({tag, "/b_stall_done"}, done, '0);
        end
        u_if.bus_b_ready = 1'b1;
        tick;
        chk({tag, "/done"}, done, oh(exp_w));
        chk({tag, "/done_resp"}, done_resp, resp);
        chk({tag, "/gnt_clear"}, gnt, '0);
        chk({tag, "/busy_low"}, busy, 0);
        bus_idle();
        m_last_resp = resp;
    endtask

    logic [NUM_REQ-1:0] g;
    int seq_b [4] = '{1, 3, 1, 3};

    initial begin
        bus_idle();
        rand_fields();
        #1;
        check_reset_outputs("reset");
        tick;
        tick;
        areset_n = 1'b1;

        // Single requester, fixed command.
        rand_fields();
        req_addr[0 +: AW] = AW'(32'h100);
        req_len[0 +: LW]  = LW'(3);
        req = 4'b0001;
        do_txn("single", 0, 0, 0, 2'b00, -1, 1'b0, g);
        req = '0;

        // Two requesters held: alternate.
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            rand_fields();
            do_txn("simul", $urandom_range(0, 2), 0, $urandom_range(0, 2), 2'b00, -1, 1'b0, g);
            chk("simul_order", g, oh(seq_b[i]));
        end

        // All requesting: strict rotation.
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            rand_fields();
            do_txn("fair", 0, 2, 0, 2'($urandom), -1, 1'b0, g);
            chk("fair_order", g, oh(i % NUM_REQ));
        end

        // AW held off, W ready toggling.
        rand_fields();
        req_len[1*LW +: LW] = LW'(3);
        req = 4'b0010;
        do_txn("backpressure", 5, 1, 1, 2'b00, -1, 1'b0, g);

        req = 4'b0001;
        rand_fields();
        do_txn("resp_err", 0, 0, 0, 2'b10, -1, 1'b0, g);

        // Reset after two data beats, then a clean grant from the reset pointer.
        rand_fields();
        req_len[0 +: LW] = LW'(5);
        req = 4'b0001;
        do_txn("abort", 0, 0, 0, 2'b00, 2, 1'b0, g);
        req = 4'b0100;
        rand_fields();
        do_txn("after_reset", 0, 0, 0, 2'b01, -1, 1'b0, g);
        chk("after_reset_gnt", g, 4'b0100);

        for (int i = 0; i < 40; i++) begin
            req = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            rand_fields();
            do_txn("random", $urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 2),
                   2'($urandom), -1, 1'($urandom_range(0, 1)), g);
        end

`ifdef AXI_WR_ARB_WDT_EN
        chk("wdt_err_clear", wdt_err, 0);
        req = 4'b0010;
        rand_fields();
        do_txn("watchdog", 0, 0, -1, 2'b00, -1, 1'b0, g);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
